// File: rtl/programmable_delay_pkg.sv
// rtl/programmable_delay_pkg.sv - shared mode enum and delay/width helpers for the delay bank
package programmable_delay_pkg;

    typedef enum logic {
        MODE_DELAY = 1'b0,
        MODE_RING  = 1'b1
    } mode_e;

    function automatic int delay_cycles(input int code, input int nominal, input int delta);
        return nominal + delta * code;
    endfunction

    function automatic int depth_of(input int code_w, input int nominal, input int delta);
        return nominal + delta * ((1 << code_w) - 1);
    endfunction

    // Wide enough to hold DEPTH itself, not just DEPTH-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/delay_channel.sv
// rtl/delay_channel.sv - one channel: shift-register delay line or ring oscillator with deferred reconfiguration
module delay_channel
    import programmable_delay_pkg::*;
#(
    parameter int CODE_W        = 5,
    parameter int NOMINAL_DELAY = 1,
    parameter int DELTA_DELAY   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              wr_en,
    input  logic              wr_mode,
    input  logic [CODE_W-1:0] wr_code,
    output logic              pending,
    output logic              dout
);

    localparam int DEPTH = depth_of(CODE_W, NOMINAL_DELAY, DELTA_DELAY);
    localparam int DW    = cnt_width(DEPTH);

    logic [DEPTH-1:0]  sr_q, sr_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] pend_code_q, pend_code_d;
    mode_e             mode_q, mode_d;
    mode_e             pend_mode_q, pend_mode_d;
    logic              pend_q, pend_d;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic              dout_q, dout_d;

    logic [DW-1:0]     d_cur;
    logic              tap;
    logic              ring_wrap;
    logic              apply;

    always_comb begin
        d_cur = DW'(delay_cycles(int'(code_q), NOMINAL_DELAY, DELTA_DELAY));
        tap   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (d_cur == DW'(i + 1)) tap = sr_q[i];
        end
        ring_wrap = (cnt_q == d_cur - DW'(1));
    end

    always_comb begin
        sr_d        = sr_q << 1;
        sr_d[0]     = din;
        code_d      = code_q;
        mode_d      = mode_q;
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
        pend_mode_d = pend_mode_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        apply       = 1'b0;

        // A ring only takes new settings on a toggle edge so every level lasts a full D.
        if (mode_q == MODE_DELAY) begin
            dout_d = tap;
            cnt_d  = '0;
            apply  = pend_q;
        end else if (ring_wrap) begin
            dout_d = ~dout_q;
            cnt_d  = '0;
            apply  = pend_q;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end

        if (apply) begin
            code_d = pend_code_q;
            mode_d = pend_mode_q;
            pend_d = 1'b0;
            if (mode_q == MODE_DELAY && pend_mode_q == MODE_RING) dout_d = dout_q;
        end

        if (wr_en) begin
            pend_d      = 1'b1;
            pend_code_d = wr_code;
            pend_mode_d = mode_e'(wr_mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            code_q      <= '0;
            mode_q      <= MODE_DELAY;
            pend_q      <= 1'b0;
            pend_code_q <= '0;
            pend_mode_q <= MODE_DELAY;
            cnt_q       <= '0;
            dout_q      <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            code_q      <= code_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
            pend_mode_q <= pend_mode_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
        end
    end

    assign pending = pend_q;
    assign dout    = dout_q;

endmodule

// File: rtl/programmable_delay_bank.sv
// rtl/programmable_delay_bank.sv - multi-channel programmable delay / ring bank with valid/ready configuration
module programmable_delay_bank
    import programmable_delay_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int CODE_W        = 5,
    parameter int NOMINAL_DELAY = 1,
    parameter int DELTA_DELAY   = 1
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic [CHANNELS-1:0]           DIN,
    output logic [CHANNELS-1:0]           DOUT,
    input  logic                          CFG_VALID,
    output logic                          CFG_READY,
    input  logic [ch_width(CHANNELS)-1:0] CFG_CH,
    input  logic                          CFG_MODE,
    input  logic [CODE_W-1:0]             CFG_CODE
);

    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] wr_en;
    logic                ch_ok;

    // Writes to channels that do not exist are accepted and dropped.
    always_comb begin
        ch_ok     = int'(CFG_CH) < CHANNELS;
        CFG_READY = 1'b1;
        if (ch_ok) CFG_READY = ~pend[CFG_CH];
        wr_en = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_en[i] = CFG_VALID && CFG_READY && ch_ok && (int'(CFG_CH) == i);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        delay_channel #(
            .CODE_W        (CODE_W),
            .NOMINAL_DELAY (NOMINAL_DELAY),
            .DELTA_DELAY   (DELTA_DELAY)
        ) u_ch (
            .clk     (CLOCK_50),
            .rst_n   (RESET_N),
            .din     (DIN[g]),
            .wr_en   (wr_en[g]),
            .wr_mode (CFG_MODE),
            .wr_code (CFG_CODE),
            .pending (pend[g]),
            .dout    (DOUT[g])
        );
    end

endmodule

// File: tb/tb_programmable_delay_bank.sv
// tb/tb_programmable_delay_bank.sv - scoreboard bench for programmable_delay_bank (CODE_W=3, D = 2 + 3*code)
module tb_programmable_delay_bank;

    localparam int K_DOUT  = 0;
    localparam int K_RDY   = 1;
    localparam int K_DOUT3 = 2;
    localparam int K_RDY3  = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [2:0] mask;
        logic [2:0] val;
        string      tag;
    } exp_t;

    logic       CLOCK_50;
    logic       RESET_N;
    logic [1:0] DIN;
    logic [1:0] DOUT;
    logic       CFG_VALID;
    logic       CFG_READY;
    logic       CFG_CH;
    logic       CFG_MODE;
    logic [2:0] CFG_CODE;

    logic [2:0] DIN3;
    logic [2:0] DOUT3;
    logic       CFG_VALID3;
    logic       CFG_READY3;
    logic [1:0] CFG_CH3;
    logic       CFG_MODE3;
    logic [2:0] CFG_CODE3;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    programmable_delay_bank #(
        .CHANNELS(2), .CODE_W(3), .NOMINAL_DELAY(2), .DELTA_DELAY(3)
    ) u_dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .DIN      (DIN),
        .DOUT     (DOUT),
        .CFG_VALID(CFG_VALID),
        .CFG_READY(CFG_READY),
        .CFG_CH   (CFG_CH),
        .CFG_MODE (CFG_MODE),
        .CFG_CODE (CFG_CODE)
    );

    programmable_delay_bank #(
        .CHANNELS(3), .CODE_W(3), .NOMINAL_DELAY(2), .DELTA_DELAY(3)
    ) u_dut3 (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .DIN      (DIN3),
        .DOUT     (DOUT3),
        .CFG_VALID(CFG_VALID3),
        .CFG_READY(CFG_READY3),
        .CFG_CH   (CFG_CH3),
        .CFG_MODE (CFG_MODE3),
        .CFG_CODE (CFG_CODE3)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        logic [2:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d never checked", sb[i].tag, sb[i].cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_DOUT:  act = {1'b0, DOUT};
                    K_RDY:   act = {2'b00, CFG_READY};
                    K_DOUT3: act = DOUT3;
                    default: act = {2'b00, CFG_READY3};
                endcase
                n_checks++;
                if ((act & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got %b expected %b", sb[i].tag, cyc,
                             act & sb[i].mask, sb[i].val & sb[i].mask);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input int c, input int k, input logic [2:0] m, input logic [2:0] v, input string t);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.mask = m;
        e.val  = v;
        e.tag  = t;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic cfg_write(input int ch, input logic mode, input logic [2:0] code, input string tag);
        logic rdy;
        bit   done;
        CFG_VALID = 1'b1;
        CFG_CH    = 1'(ch);
        CFG_MODE  = mode;
        CFG_CODE  = code;
        done      = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge CLOCK_50);
            rdy = CFG_READY;
            @(posedge CLOCK_50);
            #1;
            if (rdy) done = 1'b1;
        end
        CFG_VALID = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: write not accepted within 64 cycles", tag);
        end
    endtask

    // One-cycle pulse on DIN[ch]; expects it exactly d cycles after its sample edge.
    task automatic pulse(input int ch, input int d, input bit other, input string tag);
        int         t0;
        logic [2:0] m;
        logic [2:0] hit;
        hit     = 3'(1 << ch);
        m       = other ? 3'b011 : hit;
        DIN[ch] = 1'b1;
        t0      = cyc + 1;
        push(t0 + d - 1, K_DOUT, m, 3'b000, {tag, "_before"});
        push(t0 + d,     K_DOUT, m, hit,    {tag, "_at"});
        push(t0 + d + 1, K_DOUT, m, 3'b000, {tag, "_after"});
        step(1);
        DIN[ch] = 1'b0;
        step(d + 2);
    endtask

    initial begin
        int a;
        RESET_N    = 1'b0;
        DIN        = '0;
        CFG_VALID  = 1'b0;
        CFG_CH     = 1'b0;
        CFG_MODE   = 1'b0;
        CFG_CODE   = '0;
        DIN3       = '0;
        CFG_VALID3 = 1'b0;
        CFG_CH3    = '0;
        CFG_MODE3  = 1'b0;
        CFG_CODE3  = '0;

        // Reset state, then asynchronous reset in the middle of a stream
        step(3);
        push(cyc, K_DOUT,  3'b011, 3'b000, "reset_dout");
        push(cyc, K_RDY,   3'b001, 3'b001, "reset_ready");
        push(cyc, K_DOUT3, 3'b111, 3'b000, "reset_dout3");
        RESET_N = 1'b1;
        step(2);
        DIN = 2'b11;
        push(cyc + 3, K_DOUT, 3'b011, 3'b011, "pre_reset_dout");
        step(4);
        RESET_N = 1'b0;
        push(cyc, K_DOUT, 3'b011, 3'b000, "async_reset_dout");
        push(cyc, K_RDY,  3'b001, 3'b001, "async_reset_ready");
        DIN = 2'b00;
        step(2);
        RESET_N = 1'b1;
        step(1);
        pulse(0, 2, 1'b1, "t1_code0");

        // ch0 DELAY code 1 -> D = 5
        cfg_write(0, 1'b0, 3'd1, "t2_write");
        step(1);
        pulse(0, 5, 1'b1, "t2_code1");

        // ch1 RING code 0 -> D = 2; applied at edge a
        cfg_write(1, 1'b1, 3'd0, "t3_write");
        a = cyc + 1;
        for (int c = a; c <= a + 7; c++)
            push(c, K_DOUT, 3'b010, (((c - a) / 2) % 2 == 1) ? 3'b010 : 3'b000, "t3_ring_d2");
        step(8);

        // RING code 2 (D=8) deferred to the toggle; code 0 and code 1 writes in flight
        for (int c = a + 8; c <= a + 12; c++)
            push(c, K_DOUT, 3'b010, (c >= a + 10) ? 3'b010 : 3'b000, "t4_enter_d8");
        cfg_write(1, 1'b1, 3'd2, "t4_write_d8");
        step(4);
        cfg_write(1, 1'b1, 3'd0, "t4_write_d2");
        for (int c = a + 13; c <= a + 30; c++)
            push(c, K_DOUT, 3'b010,
                 ((c <= a + 17) || (c >= a + 20 && c <= a + 24) || (c == a + 30)) ? 3'b010 : 3'b000,
                 "t4_ring_dout");
        for (int c = a + 13; c <= a + 21; c++)
            push(c, K_RDY, 3'b001, ((c <= a + 17) || (c == a + 19)) ? 3'b000 : 3'b001, "t4_ready");
        cfg_write(1, 1'b1, 3'd1, "t4_write_d5");
        step(11);

        // ch1 RING -> DELAY code 1 mid half-period
        for (int c = a + 31; c <= a + 41; c++)
            push(c, K_DOUT, 3'b010,
                 ((c <= a + 34) || (c == a + 37) || (c == a + 39)) ? 3'b010 : 3'b000,
                 "t6_ring_to_delay");
        for (int c = a + 31; c <= a + 35; c++)
            push(c, K_RDY, 3'b001, ((c == a + 33) || (c == a + 34)) ? 3'b000 : 3'b001, "t6_ready");
        step(1);
        DIN[1] = 1'b1;
        step(1);
        DIN[1] = 1'b0;
        cfg_write(1, 1'b0, 3'd1, "t6_write");
        DIN[1] = 1'b1;
        step(1);
        DIN[1] = 1'b0;
        step(8);

        // ch0 maximum code -> D = 23, last shift-register stage
        cfg_write(0, 1'b0, 3'd7, "t5_write");
        step(1);
        pulse(0, 23, 1'b1, "t5_code7");

        // Out-of-range channel on a three-channel bank is accepted and dropped
        CFG_VALID3 = 1'b1;
        CFG_CH3    = 2'd3;
        CFG_MODE3  = 1'b1;
        CFG_CODE3  = 3'd0;
        push(cyc, K_RDY3, 3'b001, 3'b001, "t5_drop_ready");
        step(1);
        CFG_VALID3 = 1'b0;
        for (int c = cyc + 1; c <= cyc + 6; c++)
            push(c, K_DOUT3, 3'b111, 3'b000, "t5_drop_no_effect");
        step(6);
        CFG_VALID3 = 1'b1;
        CFG_CH3    = 2'd2;
        push(cyc, K_RDY3, 3'b001, 3'b001, "t5_ch2_ready");
        step(1);
        CFG_VALID3 = 1'b0;
        push(cyc + 1, K_DOUT3, 3'b111, 3'b000, "t5_ch2_hold0");
        push(cyc + 2, K_DOUT3, 3'b111, 3'b000, "t5_ch2_hold1");
        push(cyc + 3, K_DOUT3, 3'b111, 3'b100, "t5_ch2_toggle");
        step(4);

        for (int n = 0; n < 40 && sb.size() > 0; n++) step(1);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/programmable_delay_bank.md
Name: programmable_delay_bank

Overview:
- Clocked, multi-channel successor to the free-running programmable delay/ring element.
- Each channel is programmed with a delay code. A channel runs in one of two modes:
  - DELAY mode: a digital delay line for an input bit.
  - RING mode: a self-toggling oscillator with half-period equal to the programmed delay.
- Delays are in clock cycles: D(c) = NOMINAL_DELAY + DELTA_DELAY*c.
- Codes and modes are written through a valid/ready configuration port, with glitch-safe application.

Parameters:
- CHANNELS, 2, number of independent channels.
- CODE_W, 5, delay code width; code c in [0, 2^CODE_W-1].
- NOMINAL_DELAY, 1, delay in cycles at code 0; must be >= 1.
- DELTA_DELAY, 1, added cycles per code step; must be >= 0.
- DEPTH, NOMINAL_DELAY+DELTA_DELAY*(2^CODE_W-1), derived; maximum delay and shift-register length.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- DIN  in  CHANNELS  per-channel input bit, used only in DELAY mode.
- DOUT  out  CHANNELS  per-channel delayed / oscillator output, registered.
- CFG_VALID  in  1  configuration write request.
- CFG_READY  out  1  addressed channel can accept a write (combinational from CFG_CH and pending flags).
- CFG_CH  in  clog2(CHANNELS) (min 1)  target channel.
- CFG_MODE  in  1  0 = DELAY, 1 = RING.
- CFG_CODE  in  CODE_W  new delay code.

Behaviour:
- Reset (async assert, sync release):
  - DOUT = 0; all codes = 0; all modes = DELAY.
  - Shift registers, counters and pending flags = 0.
  - CFG_READY = 1.
- Config handshake:
  - A write is accepted when CFG_VALID && CFG_READY on a rising edge.
  - The accepted {mode, code} is latched into the channel's pending register and its pending flag is set.
  - CFG_READY = !pending[CFG_CH]. There is one pending write per channel; a writer holds VALID until READY.
  - CFG_CH >= CHANNELS: CFG_READY = 1 and the write is silently dropped.
- Application of a pending write:
  - Current mode DELAY: applied on the cycle after acceptance; pending clears in that same cycle.
    - The shift register is not flushed.
    - Output taps the new depth immediately, so a shortened delay may drop or repeat in-flight bits. This is accepted and documented.
  - Current mode RING: applied only at the next toggle event, on the same edge as the toggle. Pending clears there.
    - The half-period in progress always completes with the old D.
    - No runt pulses are produced.
- DELAY mode:
  - The shift register shifts DIN[i] in every cycle.
  - DOUT[i](t) = DIN[i](t - D(code)).
  - Latency is exactly D cycles from the DIN sample edge to the DOUT change.
- RING mode:
  - cnt counts 0..D-1. At cnt == D-1, DOUT toggles and cnt returns to 0.
  - Each level lasts D cycles; the period is 2D.
  - D = 1 toggles every cycle.
- Mode switch DELAY->RING:
  - Applied on the cycle after acceptance; cnt = 0.
  - DOUT holds its current value and toggles D cycles later.
- Mode switch RING->DELAY:
  - Applied at the toggle edge.
  - From the next cycle, DOUT follows the shift register, which has kept shifting DIN throughout RING mode.
- Arithmetic and bounds:
  - D is computed at width clog2(DEPTH+1) without overflow.
  - The maximum code gives D = DEPTH, the tap at the last stage.
- Channels are fully independent. A write to one channel never perturbs another.
- Async reset mid-operation: DOUT drops to 0 immediately, pending writes are discarded, and CFG_READY returns to 1.

Decomposition:
- Package programmable_delay_pkg holds:
  - the mode enum (MODE_DELAY = 0, MODE_RING = 1);
  - the function delay_cycles(code) returning NOMINAL_DELAY+DELTA_DELAY*code;
  - the DEPTH and counter-width helpers.
- Sub-module delay_channel holds one channel's shift register, ring counter, code/mode/pending registers and output register.
- The top level holds config decode, the CFG_READY mux and the generate loop over CHANNELS.

Test Plan (CHANNELS=2, CODE_W=3, NOMINAL_DELAY=2, DELTA_DELAY=3, DEPTH=23):
1. Reset: assert RESET_N=0 mid-stream -> DOUT=2'b00 asynchronously, CFG_READY=1; after release, ch0 with DIN[0] pulse behaves with D=2 (code 0).
2. Write ch0 DELAY code=1 (D=5); one-cycle DIN[0] pulse sampled at edge t0 -> DOUT[0]=1 exactly for edge t0+5 only; DOUT[1] unaffected.
3. Write ch1 RING code=0 (D=2) -> DOUT[1] toggles every 2 cycles, period 4, first toggle 2 cycles after application.
4. ch1 RING code=2 (D=8); three cycles into a half-period, write code=0 -> CFG_READY(ch1)=0 for the remaining 5 cycles. A second write held valid meanwhile is accepted only after the toggle; the next half-period is 2 cycles; no runt pulse.
5. ch0 DELAY code=7 (D=23, max tap) -> pulse emerges exactly 23 cycles later; CFG_CH=3 write -> accepted, no state change.
6. ch1 switch RING->DELAY mid half-period -> DOUT[1] holds until the toggle edge, then tracks DIN[1] delayed by the new D.
